// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- bundle of the decode/write-back signals of regfile_sb.
//
// Ports carried (named from the register file's point of view):
//   rd_ena_i    [NRD]         per-port read enable
//   rd_addr_i   [NRD*AW]      read addresses, port k at [k*AW +: AW]
//   rd_data_o   [NRD*XLEN]    read data, port k at [k*XLEN +: XLEN]
//   rd_busy_o   [NRD]         addressed register has a pending write
//   w_ena_i / w_addr_i / w_data_i   write-back request
//   iss_ena_i / iss_addr_i          destination issue (marks busy)
//   flush_i                         clears every busy bit
//   busy_cnt_o  [AW+1]        registered count of busy registers
//
// The master modport is the pipeline side; the slave modport is the register file.
interface regfile_sb_if #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int AW   = $clog2(NREG)
);
   logic [NRD-1:0]      rd_ena_i;
   logic [NRD*AW-1:0]   rd_addr_i;
   logic [NRD*XLEN-1:0] rd_data_o;
   logic [NRD-1:0]      rd_busy_o;
   logic                w_ena_i;
   logic [AW-1:0]       w_addr_i;
   logic [XLEN-1:0]     w_data_i;
   logic                iss_ena_i;
   logic [AW-1:0]       iss_addr_i;
   logic                flush_i;
   logic [AW:0]         busy_cnt_o;

   modport master (
      output rd_ena_i, rd_addr_i, w_ena_i, w_addr_i, w_data_i,
             iss_ena_i, iss_addr_i, flush_i,
      input  rd_data_o, rd_busy_o, busy_cnt_o
   );

   modport slave (
      input  rd_ena_i, rd_addr_i, w_ena_i, w_addr_i, w_data_i,
             iss_ena_i, iss_addr_i, flush_i,
      output rd_data_o, rd_busy_o, busy_cnt_o
   );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb -- integer register file with a per-register busy scoreboard.
//
// Sits between decode (operand reads, hazard checks, destination issue) and
// write-back (result write). Register 0 is hard-wired to zero and never busy.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; clears registers, busy bits, count
//   bus   regfile_sb_if.slave: read ports, write-back, issue, flush, busy count
//
// Optional feature: define REGFILE_BYPASS_EN to forward the write-back data
// (and its busy clear) to reads of the same address in the write cycle.
module regfile_sb #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int AW   = $clog2(NREG)
) (
   input logic         clk,
   input logic         rst,
   regfile_sb_if.slave bus
);

   localparam int CW = AW + 1;

   logic [XLEN-1:0]     regs_q [NREG];
   logic [XLEN-1:0]     regs_d [NREG];
   logic [NREG-1:0]     busy_q;
   logic [NREG-1:0]     busy_d;
   logic [CW-1:0]       busy_cnt_q;
   logic [CW-1:0]       busy_cnt_d;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                w_hit;
   logic                iss_hit;

   // Address 0 is a sink: neither writes nor issues may touch it.
   assign w_hit   = bus.w_ena_i && (bus.w_addr_i != '0);
   assign iss_hit = bus.iss_ena_i && (bus.iss_addr_i != '0);

   // Next register contents: only the write-back port modifies storage.
   always_comb begin
      regs_d = regs_q;
      if (w_hit) begin
         regs_d[bus.w_addr_i] = bus.w_data_i;
      end
   end

   // Next busy vector. Assignment order encodes priority:
   // write clear < issue set (new producer wins) < flush.
   always_comb begin
      busy_d = busy_q;
      if (w_hit) begin
         busy_d[bus.w_addr_i] = 1'b0;
      end
      if (iss_hit) begin
         busy_d[bus.iss_addr_i] = 1'b1;
      end
      if (bus.flush_i) begin
         busy_d = '0;
      end
   end

   // Population count of the current busy vector; registering it makes the
   // output trail the busy bits by one edge.
   always_comb begin
      busy_cnt_d = '0;
      for (int i = 0; i < NREG; i++) begin
         busy_cnt_d = busy_cnt_d + CW'(busy_q[i]);
      end
   end

   // State registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   // Combinational read ports. Disabled ports and reset force zeros.
   always_comb begin
      logic [AW-1:0] addr;
      rd_data = '0;
      rd_busy = '0;
      addr    = '0;
      for (int k = 0; k < NRD; k++) begin
         addr = bus.rd_addr_i[k*AW +: AW];
         if (!rst && bus.rd_ena_i[k]) begin
            rd_data[k*XLEN +: XLEN] = regs_q[addr];
            rd_busy[k]              = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
            // The write-back result is forwarded; the register is only
            // still busy if a new producer issues to it in this cycle.
            if (w_hit && (bus.w_addr_i == addr)) begin
               rd_data[k*XLEN +: XLEN] = bus.w_data_i;
               rd_busy[k]              = iss_hit && (bus.iss_addr_i == addr);
            end
`endif
         end
      end
   end

   assign bus.rd_data_o  = rd_data;
   assign bus.rd_busy_o  = rd_busy;
   assign bus.busy_cnt_o = busy_cnt_q;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a per-register busy scoreboard, configurable read-port count and optional write-to-read bypass. It sits between the decode stage (reads, busy checks, destination issue) and the write-back stage (result write). It supplies operands and hazard status for the pipelined core.

## Interface

Parameters:
- `XLEN`, 64: register width in bits.
- `NREG`, 32: number of architectural registers. Power of two, at least 2.
- `NRD`, 2: number of read ports, 1 to 4.
- `AW`, `$clog2(NREG)`: address width. Derived; do not override.

Ports:
- `clk`  in  1: clock, rising-edge active.
- `rst`  in  1: reset, asynchronous, active-high. Clears all registers and busy bits.
- `rd_ena_i`  in  NRD: per-port read enable.
- `rd_addr_i`  in  NRD*AW: read addresses; port k is `[k*AW +: AW]`.
- `rd_data_o`  out  NRD*XLEN: read data; port k is `[k*XLEN +: XLEN]`.
- `rd_busy_o`  out  NRD: addressed register has a pending write.
- `w_ena_i`  in  1: write-back enable.
- `w_addr_i`  in  AW: write-back address.
- `w_data_i`  in  XLEN: write-back data.
- `iss_ena_i`  in  1: an instruction with destination `iss_addr_i` issues this cycle.
- `iss_addr_i`  in  AW: destination register of the issuing instruction.
- `flush_i`  in  1: pipeline flush; clears all busy bits.
- `busy_cnt_o`  out  AW+1: registered count of busy registers.

## Operation

- **Storage:** `NREG` x `XLEN` flops plus `NREG` busy bits.
- **Register 0:** reads as 0 and is never busy. Writes and issues to address 0 are ignored.
- **Write:** on the rising edge with `w_ena_i=1` and `w_addr_i!=0`, `regs[w_addr_i] <= w_data_i`.
- **Busy set:** on the rising edge with `iss_ena_i=1` and `iss_addr_i!=0`, `busy[iss_addr_i] <= 1`.
- **Busy clear:** on the rising edge with `w_ena_i=1` and `w_addr_i!=0`, `busy[w_addr_i] <= 0`.
- **Issue and write to the same address in one cycle:** set wins, so busy stays 1 (new producer).
- **`flush_i=1`:** all busy bits go to 0 on the edge. This has priority over issue in the same cycle. A write in the same cycle still updates data.
- **Read port k:**
  - `rst=1` or `rd_ena_i[k]=0`: `rd_data_o` is 0 and `rd_busy_o[k]` is 0.
  - Otherwise: `rd_data_o` = `regs[addr]` and `rd_busy_o[k]` = `busy[addr]`, subject to bypass (see Configuration).
- **`busy_cnt_o`:** the population count of the busy vector, registered. It reflects the busy state as of the previous edge. Range 0 to `NREG-1`.
- **Multiple ports at the same address:** every port returns identical data.

## Timing

- Read data and busy outputs are combinational from addresses and state: zero-cycle latency.
- Write data is visible to reads from the cycle after the write edge. With bypass enabled it is visible in the write cycle.
- Busy set or clear takes effect on the edge. `busy_cnt_o` trails the busy vector by one cycle.
- **Reset:** asserting `rst` at any time immediately clears all registers, busy bits and `busy_cnt_o` to 0.
  - While `rst=1`: all `rd_data_o` are 0, `rd_busy_o` is 0, and `busy_cnt_o` is 0.
  - Writes and issues presented during reset are dropped.
  - Operation resumes on the first edge after deassertion.

## Configuration

- **Macro `REGFILE_BYPASS_EN`:**
  - **Defined:** a read of address A (A != 0) while `w_ena_i=1` and `w_addr_i==A` returns `w_data_i`. In that cycle `rd_busy_o` is 0 unless `iss_ena_i=1` with `iss_addr_i==A`.
  - **Undefined:** reads return the stored value and the stored busy bit. The write is visible only after the edge.

## Test plan

- **Reset:** assert `rst` mid-run after writing 0xDEAD to x5 -> x5 reads 0 immediately, `busy_cnt_o`=0, and all `rd_busy_o` are 0.
- **Write then read:** write 0x1234 to x7, then read on port 1 -> 0x1234 on the next cycle. A same-cycle read returns the old value; with `REGFILE_BYPASS_EN` it returns 0x1234.
- **x0 handling:** write 0xFFFF to x0 and issue x0 -> x0 reads 0, is never busy, and `busy_cnt_o` is unchanged.
- **Scoreboard:**
  - Issue x3, then the next cycle `rd_busy_o`=1 and `busy_cnt_o` goes to 1 one cycle later.
  - Write x3 with a same-cycle issue of x3 -> busy stays 1.
  - Write x3 alone -> busy goes to 0.
- **Flush:** issue x1, x2 and x9, then `flush_i` together with an issue of x4 -> all busy bits are 0 and `busy_cnt_o` reads 0 two edges later.
- **Multi-port:** `NRD=4`, all ports read x6=0xA5 -> all ports return 0xA5. A port with `rd_ena_i=0` returns 0.
